onehot_decoder_buf: RTL

- Inverse of the team's 8-to-3 priority encoder: accepts an encoded index plus a "none" flag over a valid/ready handshake.
- Produces the registered one-hot vector through a 2-entry skid buffer, so back-pressure never drops a code.
- Sits downstream of encoder/arbiter stages to regenerate grant/select lines; also keeps a saturating count of delivered words.

---
 rtl/onehot_pkg.sv | 38 +++
 rtl/onehot_skid2.sv | 70 +++++++
 rtl/onehot_decoder_buf.sv | 73 +++++++
 3 files changed

// File: rtl/onehot_pkg.sv
// Shared types and decode helpers for the one-hot decoder buffer.
// The helpers work at the 256-line maximum; callers truncate to their WIDTH.
package onehot_pkg;

    localparam int MAX_W      = 256;
    localparam int MAX_CODE_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } buf_state_e;

    function automatic logic [MAX_W-1:0] decode_onehot(input logic [MAX_CODE_W-1:0] code,
                                                       input logic none, input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            r[i] = !none && (i < width) && (i == int'(code));
        return r;
    endfunction

    function automatic logic code_err(input logic [MAX_CODE_W-1:0] code,
                                      input logic none, input int width);
        return !none && (int'(code) >= width);
    endfunction

    // Mask of every line at or below the index; empty for none or out-of-range.
    function automatic logic [MAX_W-1:0] decode_thermo(input logic [MAX_CODE_W-1:0] code,
                                                       input logic none, input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            r[i] = !none && (int'(code) < width) && (i <= int'(code));
        return r;
    endfunction

endpackage

// File: rtl/onehot_skid2.sv
// Two-entry FIFO skid buffer; in_ready is registered so it never depends
// combinationally on out_ready.
module onehot_skid2
    import onehot_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state, state_nxt;
    logic [W-1:0] head, tail;
    logic         in_ready_q;
    logic         push, pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = (state != ST_EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_TWO);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_TWO;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // head is always the oldest word; tail only fills when head is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (push) head <= in_data;
                ST_ONE: begin
                    if (push && pop) head <= in_data;
                    else if (push)   tail <= in_data;
                end
                ST_TWO:   if (pop) head <= tail;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/onehot_decoder_buf.sv
// Index-to-one-hot decoder with a 2-entry skid buffer and delivered-word counter.
// Define ONEHOT_DECODER_BUF_THERMO_EN to add the buffered out_thermo mask.
module onehot_decoder_buf
    import onehot_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int CNT_W  = 16,
    localparam int CODE_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_none,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_onehot,
    output logic              out_err,
`ifdef ONEHOT_DECODER_BUF_THERMO_EN
    output logic [WIDTH-1:0]  out_thermo,
`endif
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  out_cnt
);

`ifdef ONEHOT_DECODER_BUF_THERMO_EN
    localparam int PW = 2*WIDTH + 1;
`else
    localparam int PW = WIDTH + 1;
`endif

    logic [MAX_CODE_W-1:0] code_ext;
    logic [WIDTH-1:0]      dec_onehot;
    logic                  dec_err;
    logic [PW-1:0]         in_pl, out_pl;

    assign code_ext   = MAX_CODE_W'(in_code);
    assign dec_onehot = WIDTH'(decode_onehot(code_ext, in_none, WIDTH));
    assign dec_err    = code_err(code_ext, in_none, WIDTH);

`ifdef ONEHOT_DECODER_BUF_THERMO_EN
    logic [WIDTH-1:0] dec_thermo;
    assign dec_thermo = WIDTH'(decode_thermo(code_ext, in_none, WIDTH));
    assign in_pl      = {dec_err, dec_onehot, dec_thermo};
    assign {out_err, out_onehot, out_thermo} = out_pl;
`else
    assign in_pl      = {dec_err, dec_onehot};
    assign {out_err, out_onehot} = out_pl;
`endif

    onehot_skid2 #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    // Clear wins over a same-cycle delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_cnt <= '0;
        else if (cnt_clr)
            out_cnt <= '0;
        else if (out_valid && out_ready && (out_cnt != {CNT_W{1'b1}}))
            out_cnt <= out_cnt + 1'b1;
    end

endmodule
